// File: rtl/md_issue_ctrl.sv
// Initiator side of the MDU interface: launches MD-class ops with a one-cycle
// start pulse, tracks the busy handshake and stalls D while the MDU is occupied.
module md_issue_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CW       = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        d_valid,
    input  logic [1:0]  d_md_class,
    input  logic [2:0]  d_mdu_op,
    input  logic [31:0] d_rs,
    input  logic [31:0] d_rt,
    input  logic        d_sel_hi,
    output logic        stall,
    output logic        md_start,
    output logic [2:0]  md_op,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    input  logic        md_busy,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo,
    output logic        mf_valid,
    output logic [31:0] mf_data,
    output logic        wd_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    logic [1:0]    r_state;
    logic          r_start;
    logic [2:0]    r_op;
    logic [31:0]   r_a;
    logic [31:0]   r_b;
    logic [CW-1:0] r_wait_cnt;
    logic          r_wd_err;

    logic w_req;
    logic w_hold;
    logic w_accept;
    logic w_launch;

    always_comb begin
        w_req    = d_valid && (d_md_class != 2'd0);
        w_hold   = (r_state != S_IDLE) || md_busy;
        w_accept = !reset && w_req && !w_hold;
        // Reserved ops 6-7 are accepted but never reach the MDU.
        w_launch = w_accept && (d_md_class == 2'd1 || d_md_class == 2'd2)
                   && (d_mdu_op < 3'd6);
        stall    = !reset && w_req && w_hold;
        mf_valid = !reset && d_valid && (d_md_class == 2'd3) && !w_hold;
        mf_data  = d_sel_hi ? md_hi : md_lo;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_start    <= 1'b0;
            r_op       <= 3'd0;
            r_a        <= 32'd0;
            r_b        <= 32'd0;
            r_wait_cnt <= '0;
            r_wd_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_op    <= d_mdu_op;
                        r_a     <= d_rs;
                        r_b     <= d_rt;
                        r_start <= 1'b1;
                        r_state <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_start <= 1'b0;
                    if (r_op >= 3'd4) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state    <= S_WAIT;
                        r_wait_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                    // Busy is not yet valid in the first WAIT cycle.
                    if (r_wait_cnt != '0 && !md_busy) begin
                        r_state <= S_IDLE;
                    end else if (r_wait_cnt == CW'(MAX_WAIT)) begin
                        r_wd_err <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign md_start = r_start;
    assign md_op    = r_op;
    assign md_a     = r_a;
    assign md_b     = r_b;
    assign wd_err   = r_wd_err;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl: a per-cycle vector table for mult/mflo and
// mthi/mfhi, then hand sequences for back-to-back, busy lag, watchdog and reset.
module tb_md_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        d_valid;
    logic [1:0]  d_md_class;
    logic [2:0]  d_mdu_op;
    logic [31:0] d_rs, d_rt;
    logic        d_sel_hi;
    logic        stall, md_start, md_busy, mf_valid, wd_err;
    logic [2:0]  md_op;
    logic [31:0] md_a, md_b, md_hi, md_lo, mf_data;

    int n_cmp = 0;
    int n_bad = 0;
    int n_start = 0;

    always #5 clk = ~clk;

    md_issue_ctrl #(.MAX_WAIT(16), .CW(5)) dut (
        .clk(clk), .reset(reset), .d_valid(d_valid), .d_md_class(d_md_class),
        .d_mdu_op(d_mdu_op), .d_rs(d_rs), .d_rt(d_rt), .d_sel_hi(d_sel_hi),
        .stall(stall), .md_start(md_start), .md_op(md_op), .md_a(md_a),
        .md_b(md_b), .md_busy(md_busy), .md_hi(md_hi), .md_lo(md_lo),
        .mf_valid(mf_valid), .mf_data(mf_data), .wd_err(wd_err)
    );

    // MDU model: results written at start, busy rises the cycle after start.
    logic        m_busy;
    int          m_cnt;
    int          lat = 5;
    logic        frc_en = 1'b0;
    logic        frc_val = 1'b0;
    logic [63:0] m_prod;

    assign md_busy = frc_en ? frc_val : m_busy;

    always_comb begin
        if (md_op == 3'd0)
            m_prod = {{32{md_a[31]}}, md_a} * {{32{md_b[31]}}, md_b};
        else
            m_prod = {32'd0, md_a} * {32'd0, md_b};
    end

    always @(posedge clk) begin
        if (md_start) n_start <= n_start + 1;
        if (reset) begin
            m_busy <= 1'b0; m_cnt <= 0; md_hi <= 32'd0; md_lo <= 32'd0;
        end else if (md_start) begin
            case (md_op)
                3'd0, 3'd1: begin md_hi <= m_prod[63:32]; md_lo <= m_prod[31:0]; end
                3'd2: if (md_b != 0) begin
                    md_lo <= $signed(md_a) / $signed(md_b);
                    md_hi <= $signed(md_a) % $signed(md_b);
                end
                3'd3: if (md_b != 0) begin
                    md_lo <= md_a / md_b;
                    md_hi <= md_a % md_b;
                end
                3'd4: md_hi <= md_a;
                3'd5: md_lo <= md_a;
                default: ;
            endcase
            if (md_op < 3'd4) begin m_busy <= 1'b1; m_cnt <= lat; end
        end else if (m_cnt != 0) begin
            m_cnt  <= m_cnt - 1;
            m_busy <= (m_cnt > 1);
        end
    end

    typedef struct {
        logic v; logic [1:0] cls; logic [2:0] op; logic [31:0] rs, rt; logic sel;
        logic e_stall, e_start; logic [2:0] e_op; logic [31:0] e_a, e_b;
        logic e_mfv; logic [31:0] e_mfd; logic e_wd;
    } vec_t;

    vec_t tv[16];

    function automatic vec_t mk(logic v, logic [1:0] cls, logic [2:0] op,
                                logic [31:0] rs, logic [31:0] rt, logic sel,
                                logic e_stall, logic e_start, logic [2:0] e_op,
                                logic [31:0] e_a, logic [31:0] e_b, logic e_mfv,
                                logic [31:0] e_mfd, logic e_wd);
        vec_t t;
        t.v = v; t.cls = cls; t.op = op; t.rs = rs; t.rt = rt; t.sel = sel;
        t.e_stall = e_stall; t.e_start = e_start; t.e_op = e_op; t.e_a = e_a;
        t.e_b = e_b; t.e_mfv = e_mfv; t.e_mfd = e_mfd; t.e_wd = e_wd;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h @%0t", nm, got, exp, $time);
        end
    endtask

    task automatic drv(input logic v, input logic [1:0] cls, input logic [2:0] op,
                       input logic [31:0] rs, input logic [31:0] rt, input logic sel);
        d_valid = v; d_md_class = cls; d_mdu_op = op; d_rs = rs; d_rt = rt; d_sel_hi = sel;
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    initial begin
        int base;
        int kstop;
        bit found;
        logic [31:0] FD = 32'hFFFF_FFFD;

        tv[0]  = mk(1, 1, 0, 7, FD, 0,             0, 0, 0, 0, 0,       0, 0, 0);
        tv[1]  = mk(1, 3, 0, 0, 0, 0,              1, 1, 0, 7, FD,      0, 0, 0);
        for (int i = 2; i < 8; i++)
            tv[i] = mk(1, 3, 0, 0, 0, 0,           1, 0, 0, 7, FD,      0, 0, 0);
        tv[8]  = mk(1, 3, 0, 0, 0, 0,              0, 0, 0, 7, FD,      1, 32'hFFFF_FFEB, 0);
        tv[9]  = mk(0, 0, 0, 0, 0, 0,              0, 0, 0, 7, FD,      0, 0, 0);
        tv[10] = mk(1, 2, 4, 32'h1234, 0, 0,       0, 0, 0, 7, FD,      0, 0, 0);
        tv[11] = mk(1, 3, 0, 0, 0, 1,              1, 1, 4, 32'h1234, 0, 0, 0, 0);
        tv[12] = mk(1, 3, 0, 0, 0, 1,              0, 0, 4, 32'h1234, 0, 1, 32'h1234, 0);
        tv[13] = mk(1, 1, 6, 32'hDEAD, 32'hBEEF, 0, 0, 0, 4, 32'h1234, 0, 0, 0, 0);
        tv[14] = mk(1, 3, 0, 0, 0, 1,              0, 0, 4, 32'h1234, 0, 1, 32'h1234, 0);
        tv[15] = mk(0, 0, 0, 0, 0, 0,              0, 0, 4, 32'h1234, 0, 0, 0, 0);

        // Reset with a pending move-from and busy forced high.
        reset = 1'b1; frc_en = 1'b1; frc_val = 1'b1;
        drv(1, 3, 0, 0, 0, 1);
        @(negedge clk);
        chk("rst_stall", stall, 0);
        chk("rst_mfv", mf_valid, 0);
        nxt();
        @(negedge clk);
        chk("rst_start", md_start, 0);
        chk("rst_wd", wd_err, 0);
        chk("rst_op", md_op, 0);
        chk("rst_a", md_a, 0);
        chk("rst_b", md_b, 0);
        nxt();
        reset = 1'b0; frc_en = 1'b0; drv(0, 0, 0, 0, 0, 0);
        nxt();

        // Vector table: mult 7*-3 + mflo, mthi + mfhi, reserved op.
        lat = 5;
        for (int i = 0; i < 16; i++) begin
            drv(tv[i].v, tv[i].cls, tv[i].op, tv[i].rs, tv[i].rt, tv[i].sel);
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), stall, tv[i].e_stall);
            chk($sformatf("v%0d_start", i), md_start, tv[i].e_start);
            chk($sformatf("v%0d_op", i), md_op, tv[i].e_op);
            chk($sformatf("v%0d_a", i), md_a, tv[i].e_a);
            chk($sformatf("v%0d_b", i), md_b, tv[i].e_b);
            chk($sformatf("v%0d_mfv", i), mf_valid, tv[i].e_mfv);
            if (tv[i].e_mfv) chk($sformatf("v%0d_mfd", i), mf_data, tv[i].e_mfd);
            chk($sformatf("v%0d_wd", i), wd_err, tv[i].e_wd);
            nxt();
        end

        // divu then div back-to-back, MDU latency 10.
        lat = 10;
        base = n_start;
        drv(1, 1, 3, 100, 7, 0);
        @(negedge clk);
        chk("b2b_first_stall", stall, 0);
        nxt();
        drv(1, 1, 2, 32'hFFFF_FF9C, 7, 0);
        found = 0; kstop = -1;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (!stall) begin found = 1; kstop = k; end
            else nxt();
        end
        chk("b2b_found", found, 1);
        chk("b2b_stall_cycles", kstop, 12);
        nxt();
        drv(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("b2b_start2", md_start, 1);
        chk("b2b_op2", md_op, 2);
        chk("b2b_a2", md_a, 32'hFFFF_FF9C);
        nxt(); nxt();
        @(negedge clk);
        chk("nonmd_no_stall", stall, 0);
        nxt();
        drv(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 14; k++) nxt();
        chk("b2b_pulses", n_start - base, 2);
        drv(1, 3, 0, 0, 0, 0);
        @(negedge clk);
        chk("div_lo_mfv", mf_valid, 1);
        chk("div_lo", mf_data, 32'hFFFF_FFF2);
        nxt();

        // Busy lag: busy 0 in the first WAIT cycle, then 1 for three cycles.
        lat = 1; frc_en = 1'b1; frc_val = 1'b0;
        drv(1, 1, 0, 3, 4, 0);
        @(negedge clk);
        chk("lag_accept", stall, 0);
        nxt();
        drv(1, 3, 0, 0, 0, 0);
        for (int k = 0; k < 7; k++) begin
            frc_val = (k >= 2 && k <= 4);
            @(negedge clk);
            chk($sformatf("lag_stall%0d", k), stall, (k < 6));
            if (k == 6) begin
                chk("lag_mfv", mf_valid, 1);
                chk("lag_mfd", mf_data, 32'd12);
            end
            nxt();
        end

        // Watchdog: busy stuck high after a mult.
        frc_val = 1'b0;
        drv(1, 1, 0, 1, 1, 0);
        @(negedge clk);
        chk("wd_accept", stall, 0);
        nxt();
        frc_val = 1'b1;
        drv(1, 3, 0, 0, 0, 0);
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            chk($sformatf("wd_stall%0d", k), stall, 1);
            chk($sformatf("wd_pre%0d", k), wd_err, 0);
            nxt();
        end
        frc_en = 1'b0;
        @(negedge clk);
        chk("wd_set", wd_err, 1);
        chk("wd_idle_stall", stall, 0);
        chk("wd_idle_mfv", mf_valid, 1);
        nxt();
        drv(0, 0, 0, 0, 0, 0);
        nxt(); nxt();
        @(negedge clk);
        chk("wd_sticky", wd_err, 1);
        nxt();

        // Reset asserted while in WAIT with a pending mfhi.
        frc_en = 1'b1; frc_val = 1'b0;
        drv(1, 1, 0, 5, 5, 0);
        nxt();
        frc_val = 1'b1;
        drv(1, 3, 0, 0, 0, 1);
        nxt(); nxt(); nxt();
        @(negedge clk);
        chk("rw_pre_stall", stall, 1);
        nxt();
        reset = 1'b1; frc_en = 1'b0;
        @(negedge clk);
        chk("rw_rst_stall", stall, 0);
        chk("rw_rst_mfv", mf_valid, 0);
        nxt();
        reset = 1'b0;
        @(negedge clk);
        chk("rw_start", md_start, 0);
        chk("rw_wd", wd_err, 0);
        chk("rw_stall", stall, 0);
        chk("rw_mfv", mf_valid, 1);
        chk("rw_hi", mf_data, 0);
        nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
